// File: rtl/rms_pkg.sv
// rms_pkg: shared types and defaults for the register file / call-frame stack.
//   state_t      - frame engine states (IDLE, SAVE, RESTORE)
//   DEF_*        - default parameter values used by the interface and modules
//   depthWidth() - width needed to hold a frame count 0..frameDepth
package rms_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE
  } state_t;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_SAVE_BASE   = 1;
  localparam int DEF_NSAVE       = 15;
  localparam int DEF_FRAME_DEPTH = 8;
  localparam int DEF_IO_ADDR     = 63;

  function automatic int depthWidth(input int frameDepth);
    return $clog2(frameDepth + 1);
  endfunction

endpackage

// File: rtl/regfile_ctx_stack_if.sv
// regfile_ctx_stack_if: decode-side bus of the register file / frame stack.
//   read ports  : r1_addr/r2_addr in, r1_data/r2_data out (1-cycle latency)
//   write ports : w1_en/w1_addr/w1_data, w2_en/w2_addr/w2_data
//   frame ctrl  : call_req, ret_req, clr_err in; busy, depth, overflow, underflow out
//   io          : io_in (read at IO_ADDR), io_out (last write to IO_ADDR)
// master = decode / testbench side, slave = regfile_ctx_stack.
interface regfile_ctx_stack_if import rms_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH_W = depthWidth(DEF_FRAME_DEPTH)
);
  logic [ADDR_W-1:0]  r1_addr, r2_addr;
  logic [WIDTH-1:0]   r1_data, r2_data;
  logic               w1_en, w2_en;
  logic [ADDR_W-1:0]  w1_addr, w2_addr;
  logic [WIDTH-1:0]   w1_data, w2_data;
  logic               call_req, ret_req, clr_err;
  logic               busy, overflow, underflow;
  logic [DEPTH_W-1:0] depth;
  logic [WIDTH-1:0]   io_in, io_out;

  modport master (
    output r1_addr, r2_addr, w1_en, w1_addr, w1_data, w2_en, w2_addr, w2_data,
           call_req, ret_req, clr_err, io_in,
    input  r1_data, r2_data, busy, depth, overflow, underflow, io_out
  );

  modport slave (
    input  r1_addr, r2_addr, w1_en, w1_addr, w1_data, w2_en, w2_addr, w2_data,
           call_req, ret_req, clr_err, io_in,
    output r1_data, r2_data, busy, depth, overflow, underflow, io_out
  );
endinterface

// File: rtl/regfile_ctx_stack_frame_ram.sv
// frame_ram: single-port synchronous RAM holding saved register frames.
//   clk   - clock
//   we    - write enable (write has priority; no read that cycle)
//   addr  - word address
//   wdata - write data
//   rdata - read data, valid one cycle after the address is presented
// Contents are intentionally not reset.
module frame_ram import rms_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_FRAME_DEPTH * DEF_NSAVE,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end
endmodule

// File: rtl/regfile_ctx_stack.sv
// regfile_ctx_stack: 2R/2W register file with IO-mapped register and a
// hardware call-frame stack that saves/restores registers
// [SAVE_BASE, SAVE_BASE+NSAVE) one word per cycle through frame_ram.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - regfile_ctx_stack_if.slave (read/write ports, call/ret,
//                busy/depth/flags, io_in/io_out)
// Optional: define RF_BYPASS_EN to forward same-cycle port writes into the
// registered read data. The IO address is never forwarded; it always
// returns io_in.
module regfile_ctx_stack import rms_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SAVE_BASE   = DEF_SAVE_BASE,
  parameter int NSAVE       = DEF_NSAVE,
  parameter int FRAME_DEPTH = DEF_FRAME_DEPTH,
  parameter int IO_ADDR     = DEF_IO_ADDR
) (
  input logic clk,
  input logic reset,
  regfile_ctx_stack_if.slave bus
);
  localparam int NREG      = 2 ** ADDR_W;
  localparam int DEPTH_W   = depthWidth(FRAME_DEPTH);
  localparam int CNT_W     = $clog2(NSAVE + 1);
  localparam int RAM_WORDS = FRAME_DEPTH * NSAVE;
  localparam int RAM_AW    = $clog2(RAM_WORDS);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DEPTH_W-1:0] depthQ;
  logic               busyQ, ovfQ, unfQ;

  logic [WIDTH-1:0]   rf [NREG];
  logic [WIDTH-1:0]   r1Q, r2Q, ioOutQ, r1Next, r2Next;
  logic               w1Ok, w2Ok;

  logic               ramWe;
  logic [RAM_AW-1:0]  ramAddr;
  logic [WIDTH-1:0]   ramWdata, ramRdata;

  function automatic logic inWindow(input logic [ADDR_W-1:0] a);
    return (int'(a) >= SAVE_BASE) && (int'(a) < SAVE_BASE + NSAVE);
  endfunction

  // Read mux: address 0 is hardwired, IO address reflects io_in.
  function automatic logic [WIDTH-1:0] readPort(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (a == '0)                 v = '0;
    else if (int'(a) == IO_ADDR) v = bus.io_in;
    else begin
      v = rf[a];
`ifdef RF_BYPASS_EN
      if (w1Ok && bus.w1_addr == a) v = bus.w1_data;
      if (w2Ok && bus.w2_addr == a) v = bus.w2_data;
`endif
    end
    return v;
  endfunction

  // The saved window is frozen while a frame moves so the RAM sees a
  // consistent snapshot and a restore never races a port write.
  always_comb begin
    w1Ok   = bus.w1_en && (bus.w1_addr != '0) && !(busyQ && inWindow(bus.w1_addr));
    w2Ok   = bus.w2_en && (bus.w2_addr != '0) && !(busyQ && inWindow(bus.w2_addr));
    r1Next = readPort(bus.r1_addr);
    r2Next = readPort(bus.r2_addr);
  end

  // RAM addressing: SAVE writes frame `depth`, RESTORE reads frame depth-1.
  // Index/frame are clamped so idle and the last restore cycle stay in range.
  always_comb begin
    int frame, idx;
    ramWe = (state == SAVE);
    idx   = (int'(cnt) < NSAVE) ? int'(cnt) : NSAVE - 1;
    frame = (state == RESTORE) ? int'(depthQ) - 1 : int'(depthQ);
    if (frame < 0)            frame = 0;
    if (frame >= FRAME_DEPTH) frame = FRAME_DEPTH - 1;
    ramAddr  = RAM_AW'(frame * NSAVE + idx);
    ramWdata = rf[ADDR_W'(SAVE_BASE + idx)];
  end

  frame_ram #(.WIDTH(WIDTH), .WORDS(RAM_WORDS), .AW(RAM_AW)) uFrameRam (
    .clk   (clk),
    .we    (ramWe),
    .addr  (ramAddr),
    .wdata (ramWdata),
    .rdata (ramRdata)
  );

  // Register array, read registers and IO output. w2 is applied last so it
  // wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) rf[k] <= '0;
      r1Q    <= '0;
      r2Q    <= '0;
      ioOutQ <= '0;
    end else begin
      r1Q <= r1Next;
      r2Q <= r2Next;
      if (w1Ok) begin
        if (int'(bus.w1_addr) == IO_ADDR) ioOutQ <= bus.w1_data;
        else                              rf[bus.w1_addr] <= bus.w1_data;
      end
      if (w2Ok) begin
        if (int'(bus.w2_addr) == IO_ADDR) ioOutQ <= bus.w2_data;
        else                              rf[bus.w2_addr] <= bus.w2_data;
      end
      // cnt==0 is the prime cycle; afterwards RAM data lags the index by one.
      if (state == RESTORE && cnt != '0)
        rf[ADDR_W'(SAVE_BASE + int'(cnt) - 1)] <= ramRdata;
    end
  end

  // Frame engine with registered busy/depth/flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      depthQ <= '0;
      busyQ  <= 1'b0;
      ovfQ   <= 1'b0;
      unfQ   <= 1'b0;
    end else begin
      ovfQ <= ovfQ & ~bus.clr_err;
      unfQ <= unfQ & ~bus.clr_err;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.call_req) begin
            if (depthQ < DEPTH_W'(FRAME_DEPTH)) begin
              state <= SAVE;
              busyQ <= 1'b1;
            end else begin
              ovfQ <= 1'b1;
            end
          end else if (bus.ret_req) begin
            if (depthQ != '0) begin
              state <= RESTORE;
              busyQ <= 1'b1;
            end else begin
              unfQ <= 1'b1;
            end
          end
        end
        SAVE: begin
          if (cnt == CNT_W'(NSAVE - 1)) begin
            state  <= IDLE;
            busyQ  <= 1'b0;
            cnt    <= '0;
            depthQ <= depthQ + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESTORE: begin
          if (cnt == CNT_W'(NSAVE)) begin
            state  <= IDLE;
            busyQ  <= 1'b0;
            cnt    <= '0;
            depthQ <= depthQ - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busyQ <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.r1_data   = r1Q;
  assign bus.r2_data   = r2Q;
  assign bus.io_out    = ioOutQ;
  assign bus.busy      = busyQ;
  assign bus.depth     = depthQ;
  assign bus.overflow  = ovfQ;
  assign bus.underflow = unfQ;

endmodule

// File: tb/tb_regfile_ctx_stack.sv
// tb_regfile_ctx_stack: directed test-plan sequences followed by randomized
// traffic, every cycle compared against a behavioural model (register array,
// frame stack as a queue, save/restore progress tracked by elapsed cycles).
module tb_regfile_ctx_stack;
  import rms_pkg::*;

  localparam int WIDTH = 16, ADDR_W = 6, SAVE_BASE = 1, NSAVE = 15;
  localparam int FRAME_DEPTH = 8, IO_ADDR = 63, NREG = 64;
  localparam int DEPTH_W = depthWidth(FRAME_DEPTH);
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [NSAVE-1:0][WIDTH-1:0] frame_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_ctx_stack_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) bus ();

  regfile_ctx_stack #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .SAVE_BASE(SAVE_BASE), .NSAVE(NSAVE),
    .FRAME_DEPTH(FRAME_DEPTH), .IO_ADDR(IO_ADDR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference model state
  logic [WIDTH-1:0] mRf [NREG];
  logic [WIDTH-1:0] mR1, mR2, mIo;
  int               mDepth, mMode, mElapsed;  // mode: 0 idle, 1 saving, 2 restoring
  bit               mOvf, mUnf;
  frame_t           stk[$];
  frame_t           snap;

  int nVec = 0, nErr = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s @cyc %0d: got %h, want %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit inWin(input int a);
    return a >= SAVE_BASE && a < SAVE_BASE + NSAVE;
  endfunction

  function automatic logic [WIDTH-1:0] rdRef(input int a, input bit ok1, input bit ok2);
    if (a == 0) return '0;
    if (a == IO_ADDR) return bus.io_in;
    if (BYP && ok2 && int'(bus.w2_addr) == a) return bus.w2_data;
    if (BYP && ok1 && int'(bus.w1_addr) == a) return bus.w1_data;
    return mRf[a];
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NREG; k++) mRf[k] = '0;
    mR1 = '0; mR2 = '0; mIo = '0;
    mDepth = 0; mMode = 0; mElapsed = 0; mOvf = 0; mUnf = 0;
    stk.delete();
  endtask

  task automatic modelEdge();
    bit busyBefore, ok1, ok2, setO, setU;
    int a1, a2;
    busyBefore = (mMode != 0);
    setO = 0; setU = 0;
    a1 = int'(bus.w1_addr); a2 = int'(bus.w2_addr);
    ok1 = bus.w1_en && a1 != 0 && !(busyBefore && inWin(a1));
    ok2 = bus.w2_en && a2 != 0 && !(busyBefore && inWin(a2));
    mR1 = rdRef(int'(bus.r1_addr), ok1, ok2);
    mR2 = rdRef(int'(bus.r2_addr), ok1, ok2);
    if (ok1) begin if (a1 == IO_ADDR) mIo = bus.w1_data; else mRf[a1] = bus.w1_data; end
    if (ok2) begin if (a2 == IO_ADDR) mIo = bus.w2_data; else mRf[a2] = bus.w2_data; end
    case (mMode)
      0: begin
        if (bus.call_req) begin
          if (mDepth < FRAME_DEPTH) begin
            mMode = 1; mElapsed = 0;
            for (int i = 0; i < NSAVE; i++) snap[i] = mRf[SAVE_BASE + i];
          end else setO = 1;
        end else if (bus.ret_req) begin
          if (mDepth > 0) begin
            mMode = 2; mElapsed = 0; snap = stk.pop_back();
          end else setU = 1;
        end
      end
      1: begin
        mElapsed++;
        if (mElapsed == NSAVE) begin stk.push_back(snap); mDepth++; mMode = 0; end
      end
      default: begin
        mElapsed++;
        if (mElapsed >= 2) mRf[SAVE_BASE + mElapsed - 2] = snap[mElapsed - 2];
        if (mElapsed == NSAVE + 1) begin mDepth--; mMode = 0; end
      end
    endcase
    mOvf = setO || (mOvf && !bus.clr_err);
    mUnf = setU || (mUnf && !bus.clr_err);
  endtask

  task automatic chkAll();
    chk("r1_data",   32'(bus.r1_data),   32'(mR1));
    chk("r2_data",   32'(bus.r2_data),   32'(mR2));
    chk("io_out",    32'(bus.io_out),    32'(mIo));
    chk("busy",      32'(bus.busy),      32'(mMode != 0));
    chk("depth",     32'(bus.depth),     32'(mDepth));
    chk("overflow",  32'(bus.overflow),  32'(mOvf));
    chk("underflow", 32'(bus.underflow), 32'(mUnf));
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    modelEdge();
    #1;
    chkAll();
  endtask

  task automatic idleIn();
    bus.w1_en = 0; bus.w2_en = 0; bus.call_req = 0; bus.ret_req = 0; bus.clr_err = 0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    #2;
    modelReset();
    chkAll();
    reset = 1'b0;
  endtask

  // Counts samples with busy high, starting with the current one.
  task automatic runIdle(output int nb);
    int guard;
    nb = 0; guard = 0;
    while (bus.busy === 1'b1 && guard < 100) begin
      nb++; cycle(); guard++;
    end
    if (guard >= 100) chk("busy_timeout", 32'(bus.busy), 0);
  endtask

  task automatic pulse(input bit isCall);
    int nb;
    idleIn();
    if (isCall) bus.call_req = 1; else bus.ret_req = 1;
    cycle();
    idleIn();
    runIdle(nb);
  endtask

  initial begin
    int nb;
    bus.r1_addr = 0; bus.r2_addr = 0; bus.w1_addr = 0; bus.w2_addr = 0;
    bus.w1_data = 0; bus.w2_data = 0; bus.io_in = 16'h0000;
    idleIn();
    applyReset();

    // basic write/read, address 0
    bus.w1_en = 1; bus.w1_addr = 5; bus.w1_data = 16'h1234; cycle();
    idleIn(); bus.r1_addr = 5; bus.r2_addr = 0; cycle();
    chk("tp_r5", 32'(bus.r1_data), 32'h1234);
    chk("tp_r0", 32'(bus.r2_data), 32'h0);

    // write collision and IO register
    bus.w1_en = 1; bus.w1_addr = 7; bus.w1_data = 16'hAAAA;
    bus.w2_en = 1; bus.w2_addr = 7; bus.w2_data = 16'h5555; cycle();
    idleIn(); bus.r1_addr = 7; cycle();
    chk("tp_r7_w2wins", 32'(bus.r1_data), 32'h5555);
    bus.w1_en = 1; bus.w1_addr = 6'(IO_ADDR); bus.w1_data = 16'h00FF; cycle();
    chk("tp_io_out", 32'(bus.io_out), 32'h00FF);
    idleIn(); bus.io_in = 16'hCAFE; bus.r1_addr = 6'(IO_ADDR); cycle();
    chk("tp_io_in", 32'(bus.r1_data), 32'hCAFE);

    // save/restore round trip
    for (int i = 1; i <= 15; i++) begin
      bus.w1_en = 1; bus.w1_addr = 6'(i); bus.w1_data = 16'(i * 16'h0101); cycle();
    end
    idleIn(); bus.call_req = 1; cycle(); idleIn(); runIdle(nb);
    chk("save_busy_cycles", 32'(nb), 15);
    chk("save_depth", 32'(bus.depth), 1);
    for (int i = 1; i <= 15; i++) begin
      bus.w1_en = 1; bus.w1_addr = 6'(i); bus.w1_data = 16'h0; cycle();
    end
    idleIn(); bus.ret_req = 1; cycle(); idleIn(); runIdle(nb);
    chk("restore_busy_cycles", 32'(nb), 16);
    chk("restore_depth", 32'(bus.depth), 0);
    for (int i = 1; i <= 15; i++) begin
      bus.r1_addr = 6'(i); cycle();
      chk("restore_val", 32'(bus.r1_data), 32'(i * 16'h0101));
    end

    // overflow / underflow / clear
    for (int k = 0; k < FRAME_DEPTH; k++) pulse(1'b1);
    bus.call_req = 1; cycle(); idleIn();
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_depth", 32'(bus.depth), 8);
    for (int k = 0; k < FRAME_DEPTH; k++) pulse(1'b0);
    bus.ret_req = 1; cycle(); idleIn();
    chk("unf_set", 32'(bus.underflow), 1);
    bus.clr_err = 1; cycle(); idleIn();
    chk("clr_ovf", 32'(bus.overflow), 0);
    chk("clr_unf", 32'(bus.underflow), 0);

    // writes and calls while busy
    bus.call_req = 1; cycle(); idleIn();
    bus.w1_en = 1; bus.w1_addr = 3; bus.w1_data = 16'hDEAD;
    bus.w2_en = 1; bus.w2_addr = 20; bus.w2_data = 16'hBEEF;
    bus.call_req = 1; cycle(); idleIn(); runIdle(nb);
    chk("busy_call_ignored", 32'(bus.depth), 1);
    bus.r1_addr = 3; bus.r2_addr = 20; cycle();
    chk("busy_win_drop", 32'(bus.r1_data), 32'h0303);
    chk("busy_other_ok", 32'(bus.r2_data), 32'hBEEF);

    // reset in the middle of a save
    bus.call_req = 1; cycle(); idleIn();
    for (int k = 0; k < 6; k++) cycle();
    applyReset();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_depth", 32'(bus.depth), 0);
    bus.r1_addr = 5; bus.r2_addr = 20; cycle();
    chk("rst_r5", 32'(bus.r1_data), 0);
    chk("rst_r20", 32'(bus.r2_data), 0);

    // same-cycle write and read
    bus.w1_en = 1; bus.w1_addr = 9; bus.w1_data = 16'h4321; bus.r1_addr = 9; cycle();
    idleIn();
`ifdef RF_BYPASS_EN
    chk("bypass_r9", 32'(bus.r1_data), 32'h4321);
`else
    chk("nobypass_r9", 32'(bus.r1_data), 32'h0);
`endif
    cycle();
    chk("r9_after", 32'(bus.r1_data), 32'h4321);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      bus.r1_addr = (sel == 0) ? 6'(IO_ADDR) : (sel == 3) ? 6'($urandom) : 6'($urandom_range(0, 16));
      bus.r2_addr = 6'($urandom);
      bus.w1_en   = 1'($urandom_range(0, 1));
      bus.w1_addr = (sel == 1) ? 6'(IO_ADDR) : 6'($urandom_range(0, 20));
      bus.w1_data = 16'($urandom);
      bus.w2_en   = 1'($urandom_range(0, 1));
      bus.w2_addr = (sel == 2) ? bus.w1_addr : 6'($urandom);
      bus.w2_data = 16'($urandom);
      bus.call_req = ($urandom_range(0, 15) == 0);
      bus.ret_req  = ($urandom_range(0, 12) == 0);
      bus.clr_err  = ($urandom_range(0, 40) == 0);
      bus.io_in    = 16'($urandom);
      cycle();
      if ($urandom_range(0, 999) == 0) applyReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/regfile_ctx_stack.md
Name: regfile_ctx_stack

Overview:
Parametrised successor to the processor's register management block. Holds a 2-read/2-write register file with a memory-mapped IO register, plus a hardware call-frame stack. The stack saves and restores a contiguous window of registers on call/return, replacing the wide parallel save/restore buses. Sits between instruction decode and the ALU/memory stages; it drives the A/B operand registers and the IO output.

Parameters:
WIDTH, 16, data width of every register
ADDR_W, 6, register address width; NREG = 2**ADDR_W
SAVE_BASE, 1, first register index of the saved window
NSAVE, 15, number of registers saved per frame; SAVE_BASE+NSAVE <= NREG-1
FRAME_DEPTH, 8, maximum nested frames held
IO_ADDR, 63, register index mapped to the IO port

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
r1_addr  in  ADDR_W  read port 1 address
r2_addr  in  ADDR_W  read port 2 address
r1_data  out  WIDTH  registered read data 1 (operand A)
r2_data  out  WIDTH  registered read data 2 (operand B)
w1_en  in  1  write port 1 enable
w1_addr  in  ADDR_W  write port 1 address
w1_data  in  WIDTH  write port 1 data
w2_en  in  1  write port 2 enable
w2_addr  in  ADDR_W  write port 2 address
w2_data  in  WIDTH  write port 2 data
call_req  in  1  single-cycle pulse: push the saved window
ret_req  in  1  single-cycle pulse: pop into the saved window
busy  out  1  save/restore in progress
depth  out  $clog2(FRAME_DEPTH+1)  current frame count
overflow  out  1  sticky: call attempted when full
underflow  out  1  sticky: return attempted when empty
clr_err  in  1  clears overflow/underflow
io_in  in  WIDTH  external input, read at IO_ADDR
io_out  out  WIDTH  value last written to IO_ADDR

Behaviour:
- Reset (async): all registers 0; r1_data, r2_data, io_out = 0; busy = 0; depth = 0; overflow = underflow = 0; FSM = IDLE. Frame RAM contents are not reset.
- Reads: 1-cycle latency. r*_data is sampled at the rising edge from the array state before that edge's writes (no forwarding; see optional feature).
- Address 0 always reads 0; writes to it are dropped.
- Address IO_ADDR reads the io_in value sampled at the edge. A write to IO_ADDR updates io_out, not the array.
- Both write ports to the same address in one cycle: w2 wins.
- FSM states:
  - IDLE:
    - call_req with depth < FRAME_DEPTH -> SAVE.
    - call_req with depth == FRAME_DEPTH -> set overflow, stay IDLE.
    - ret_req with depth > 0 -> RESTORE.
    - ret_req with depth == 0 -> set underflow, stay IDLE.
    - call_req and ret_req together -> call wins; ret is ignored.
  - SAVE: index i = 0..NSAVE-1, one per cycle. frame_ram[depth*NSAVE+i] <= rf[SAVE_BASE+i]. After i = NSAVE-1: depth+1, return to IDLE. busy = 1 for exactly NSAVE cycles.
  - RESTORE: one prime cycle issues the RAM read for i = 0. Then NSAVE cycles write rf[SAVE_BASE+i] <= frame_ram[(depth-1)*NSAVE+i]. On the final write: depth-1, return to IDLE. busy = 1 for NSAVE+1 cycles.
- While busy:
  - call_req and ret_req are ignored (no flag set).
  - Writes to addresses in [SAVE_BASE, SAVE_BASE+NSAVE) are dropped.
  - Other writes and all reads proceed normally.
- clr_err clears both flags. If a flag-setting event occurs in the same cycle, the set wins.
- Reset mid-SAVE/RESTORE: immediate return to IDLE, depth = 0, partial frame discarded.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: a same-cycle write to a read address forwards the new value into r*_data. w2 takes precedence over w1, and address 0 stays 0. Writes dropped because of busy are not forwarded.
- Undefined: reads return the pre-write value, as stated above.

Decomposition:
- Package rms_pkg holds:
  - the FSM state enum (IDLE, SAVE, RESTORE);
  - the default parameter constants;
  - a function computing the depth width.
- Sub-module frame_ram: single-port synchronous RAM of FRAME_DEPTH*NSAVE words x WIDTH, with 1-cycle read latency.

Test Plan:
- Reset, then write r5 = 0x1234 via w1 and read r1_addr = 5 next cycle -> r1_data = 0x1234 one cycle after the read address is presented. A read of address 0 returns 0.
- w1 and w2 both write r7 (0xAAAA, 0x5555) in the same cycle -> r7 = 0x5555. Write 0x00FF to address 63 -> io_out = 0x00FF; read of address 63 returns io_in.
- Load r1..r15 = 0x0101..0x0F0F, pulse call_req -> busy for 15 cycles, depth = 1. Overwrite r1..r15 with 0, pulse ret_req -> busy for 16 cycles, r1..r15 restored, depth = 0.
- Push 8 frames, then a 9th call_req -> overflow = 1, depth stays 8. Pop to 0, then ret_req -> underflow = 1. clr_err -> both flags 0.
- During SAVE: write r3 -> dropped; write r20 = 0xBEEF -> accepted. call_req during busy -> ignored, depth increments only once.
- Assert reset at cycle 7 of SAVE -> busy = 0, depth = 0, all registers 0. With RF_BYPASS_EN, a same-cycle write/read of r9 = 0x4321 -> r1_data = 0x4321.
